pu_accum_seq: RTL and testbench
===============================

Name: pu_accum_seq

Overview:
- Control sequencer that drives the control-signal side of the accumulator processing unit (signal_load/init/neg/oe).
- Accepts one job descriptor per handshake: addend count plus per-addend negate mask.
- Paces loads against bus-data availability, waits out accumulator latency, then holds output-enable until the result is taken.
- Sits between the microcode/bus-control layer and one accumulator PU instance.

Parameters:
- MAX_ARGS, 8, maximum addends per job; width of the negate mask.
- CNT_WIDTH, 4, width of cmd_count; must satisfy 2**CNT_WIDTH > MAX_ARGS.
- ATTR_WIDTH, 4, width of the attribute bus returned by the accumulator.
- OVERFLOW, 1, index of the overflow bit in res_attr.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  job descriptor present.
- cmd_ready  out  1  sequencer can accept a job (IDLE only).
- cmd_count  in  CNT_WIDTH  number of addends.
- cmd_neg_mask  in  MAX_ARGS  bit i=1: negate addend i.
- cmd_err  out  1  one-cycle pulse: job rejected.
- arg_valid  in  1  addend present on accumulator data_in this cycle.
- arg_ready  out  1  addend consumed this cycle (equals signal_load).
- signal_load  out  1  to accumulator.
- signal_init  out  1  to accumulator; high on first load of a job.
- signal_neg  out  1  to accumulator; cmd_neg_mask[idx] of current load.
- signal_oe  out  1  to accumulator output enable.
- res_valid  out  1  accumulator data_out/attr_out hold the job result.
- res_ready  in  1  consumer takes the result.
- res_attr  in  ATTR_WIDTH  accumulator attr_out, sampled for the optional feature.
- res_ovf  out  1  sticky overflow flag (optional feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, all outputs 0 except cmd_ready=1. Asserting reset mid-job aborts silently; no cmd_err, no res_valid.
- Handshake rule: a transfer occurs on a cycle where valid&&ready are both high.
- States: IDLE, LOAD, SETTLE1, SETTLE2, OUT, HOLD.
- IDLE: cmd_ready=1. On cmd_valid:
  - Latch count and mask; idx<=0.
  - If count==0 or count>MAX_ARGS: pulse cmd_err next cycle and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD: arg_ready=signal_load=arg_valid; signal_init=(idx==0); signal_neg=mask[idx]. All are 0 when arg_valid=0 (stall, no timeout).
  - On a load with idx==count-1: go to SETTLE1.
  - On any other load: idx<=idx+1.
- SETTLE1, SETTLE2: all signals 0; they cover the accumulator's operand-register stage and acc-register stage.
- OUT: signal_oe=1 for one cycle (registers data_out); go to HOLD.
- HOLD: signal_oe=1, res_valid=1. On res_ready, go to IDLE; signal_oe and res_valid are 0 in the next cycle.
- Latency: last load at cycle t gives res_valid from cycle t+4. A single-addend job with no stalls takes 5 cycles from the command transfer to res_valid.
- Back-to-back: cmd_ready returns the cycle after the result transfer; there is no overlap of jobs.
- signal_oe is never high in the same cycle as signal_load.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Counter arithmetic is unsigned CNT_WIDTH; idx never exceeds count-1.

Optional Feature:
- Macro PU_ACCUM_SEQ_OVF_STICKY_EN.
- Defined:
  - res_ovf clears on each accepted cmd.
  - In HOLD, res_ovf sets if res_attr[OVERFLOW]=1 and stays set until the next accepted cmd; readable while IDLE.
- Undefined: res_ovf tied 0; res_attr unused.

Test Plan:
- Reset then cmd count=3, mask=3'b010, arg_valid always 1 -> loads on 3 consecutive cycles with init=1,0,0 and neg=0,1,0; res_valid 4 cycles after third load; an accumulator fed 5,7,2 yields data_out=0.
- cmd count=2 with arg_valid toggled 1,0,0,1 -> exactly 2 signal_load pulses, no load during stalls, init only on first.
- cmd count=0, then count=9 (MAX_ARGS=8) -> cmd_err one-cycle pulse each, no signal_load, busy stays 0, cmd_ready stays 1.
- Result ready with res_ready held 0 for 6 cycles -> signal_oe and res_valid stay 1, data_out stable; res_ready=1 -> both drop next cycle, cmd_ready=1.
- rst pulled low mid-LOAD after 1 of 4 loads -> all outputs 0 immediately; after release, IDLE with cmd_ready=1; a new job count=1 completes normally.
- With PU_ACCUM_SEQ_OVF_STICKY_EN, DATA_WIDTH=4, addends 7,1 -> res_ovf=1 in HOLD and kept through IDLE; next cmd clears it. Without the macro, res_ovf=0 throughout.

Source files
------------

// File: rtl/pu_accum_seq.sv
// pu_accum_seq
// Control sequencer for one accumulator processing unit. It accepts one job
// descriptor (addend count + per-addend negate mask) at a time. It drives
// signal_load/init/neg paced by arg_valid, then waits out the accumulator's
// two internal register stages. Next it registers the result with signal_oe
// and holds it (res_valid) until the consumer takes it.
//
// Build option: define PU_ACCUM_SEQ_OVF_STICKY_EN to enable a sticky overflow
// flag on res_ovf, captured from res_attr[OVERFLOW] while the result is held.
// Without it, res_ovf is tied low and res_attr is ignored.
module pu_accum_seq #(
  parameter int MAX_ARGS   = 8,  // maximum addends per job, width of the negate mask
  parameter int CNT_WIDTH  = 4,  // width of cmd_count; 2**CNT_WIDTH must exceed MAX_ARGS
  parameter int ATTR_WIDTH = 4,  // width of the accumulator attribute bus
  parameter int OVERFLOW   = 1   // index of the overflow bit within res_attr
) (
  input  logic                  clk,
  input  logic                  rst,           // asynchronous, active low
  // job descriptor
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic [MAX_ARGS-1:0]   cmd_neg_mask,
  output logic                  cmd_err,
  // addend pacing
  input  logic                  arg_valid,
  output logic                  arg_ready,
  // accumulator control
  output logic                  signal_load,
  output logic                  signal_init,
  output logic                  signal_neg,
  output logic                  signal_oe,
  // result handshake
  output logic                  res_valid,
  input  logic                  res_ready,
  input  logic [ATTR_WIDTH-1:0] res_attr,
  output logic                  res_ovf,
  // status
  output logic                  busy
);

  // The mask is widened to the full index range so indexing by idx_q never
  // needs a range check; the padding bits are constant zero.
  localparam int MASK_EXT_W = 1 << CNT_WIDTH;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_ARGS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE1 = 3'd2,  // accumulator operand-register stage
    ST_SETTLE2 = 3'd3,  // accumulator acc-register stage
    ST_OUT     = 3'd4,  // data_out register captures the sum
    ST_HOLD    = 3'd5   // result presented until res_ready
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [MAX_ARGS-1:0]    mask_q, mask_d;
  logic                   cmd_err_q, cmd_err_d;

  // Registered state-decoded outputs
  logic                   cmd_ready_q;
  logic                   busy_q;
  logic                   oe_q;
  logic                   res_valid_q;

  logic [MASK_EXT_W-1:0]  mask_ext;
  logic [CNT_WIDTH-1:0]   last_idx;
  logic                   count_ok;
  logic                   in_load;
  logic                   load_fire;

  assign mask_ext  = MASK_EXT_W'(mask_q);
  assign last_idx  = count_q - CNT_ONE;
  assign count_ok  = (cmd_count != '0) && (cmd_count <= MAX_CNT);
  assign in_load   = (state_q == ST_LOAD);
  assign load_fire = in_load & arg_valid;

  // Next-state and job-register update decisions
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    mask_d    = mask_q;
    cmd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          count_d = cmd_count;
          mask_d  = cmd_neg_mask;
          idx_d   = '0;
          if (count_ok) begin
            state_d = ST_LOAD;
          end else begin
            // Rejected job: report it once and remain ready for the next one
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // A stall (arg_valid low) simply waits; there is no timeout
        if (arg_valid) begin
          if (idx_q == last_idx) begin
            state_d = ST_SETTLE1;
          end else begin
            idx_d = idx_q + CNT_ONE;
          end
        end
      end
      ST_SETTLE1: state_d = ST_SETTLE2;
      ST_SETTLE2: state_d = ST_OUT;
      ST_OUT:     state_d = ST_HOLD;
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, job registers and registered status/handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      cmd_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      oe_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      cmd_err_q   <= cmd_err_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      oe_q        <= (state_d == ST_OUT) || (state_d == ST_HOLD);
      res_valid_q <= (state_d == ST_HOLD);
    end
  end

  // Load-side controls follow arg_valid in the same cycle, so they are
  // combinational from the LOAD state; everything else comes from flops.
  // signal_oe is only high in OUT/HOLD, so it can never coincide with a load.
  assign signal_load = load_fire;
  assign arg_ready   = load_fire;
  assign signal_init = load_fire & (idx_q == '0);
  assign signal_neg  = load_fire & mask_ext[idx_q];
  assign signal_oe   = oe_q;
  assign res_valid   = res_valid_q;
  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;

`ifdef PU_ACCUM_SEQ_OVF_STICKY_EN
  logic res_ovf_q;
  logic cmd_fire;

  assign cmd_fire = cmd_valid & cmd_ready_q;

  // Sticky overflow: cleared by each accepted command, set while the result
  // is held if the accumulator flags overflow, and kept through IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_ovf_q <= 1'b0;
    end else if (cmd_fire) begin
      res_ovf_q <= 1'b0;
    end else if ((state_q == ST_HOLD) && res_attr[OVERFLOW]) begin
      res_ovf_q <= 1'b1;
    end
  end

  assign res_ovf = res_ovf_q;
`else
  logic unused_res_attr;

  assign unused_res_attr = ^res_attr;
  assign res_ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_pu_accum_seq.sv
// tb_pu_accum_seq: directed bench for pu_accum_seq with a small behavioural
// accumulator (operand register, acc register, output register) attached.
module tb_pu_accum_seq;

  localparam int MAX_ARGS   = 8;
  localparam int CNT_WIDTH  = 4;
  localparam int ATTR_WIDTH = 4;
  localparam int OVERFLOW   = 1;
  localparam int DW         = 4;

`ifdef PU_ACCUM_SEQ_OVF_STICKY_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CNT_WIDTH-1:0]  cmd_count;
  logic [MAX_ARGS-1:0]   cmd_neg_mask;
  logic                  cmd_err;
  logic                  arg_valid;
  logic                  arg_ready;
  logic                  signal_load;
  logic                  signal_init;
  logic                  signal_neg;
  logic                  signal_oe;
  logic                  res_valid;
  logic                  res_ready;
  logic [ATTR_WIDTH-1:0] res_attr;
  logic                  res_ovf;
  logic                  busy;

  pu_accum_seq #(
    .MAX_ARGS  (MAX_ARGS),
    .CNT_WIDTH (CNT_WIDTH),
    .ATTR_WIDTH(ATTR_WIDTH),
    .OVERFLOW  (OVERFLOW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_count   (cmd_count),
    .cmd_neg_mask(cmd_neg_mask),
    .cmd_err     (cmd_err),
    .arg_valid   (arg_valid),
    .arg_ready   (arg_ready),
    .signal_load (signal_load),
    .signal_init (signal_init),
    .signal_neg  (signal_neg),
    .signal_oe   (signal_oe),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_attr    (res_attr),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Behavioural accumulator driven by the sequencer's control signals
  logic [DW-1:0]         data_in;
  logic [DW-1:0]         op_q;
  logic                  op_v_q = 1'b0;
  logic                  op_init_q;
  logic [DW-1:0]         acc_q;
  logic                  acc_ovf_q;
  logic [DW-1:0]         data_out;
  logic [ATTR_WIDTH-1:0] attr_out = '0;
  logic [DW-1:0]         sum;
  logic                  sum_ovf;

  assign sum      = acc_q + op_q;
  assign sum_ovf  = (acc_q[DW-1] == op_q[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
  assign res_attr = attr_out;

  always @(posedge clk) begin
    op_v_q <= signal_load;
    if (signal_load) begin
      op_q      <= signal_neg ? -data_in : data_in;
      op_init_q <= signal_init;
    end
    if (op_v_q) begin
      if (op_init_q) begin
        acc_q     <= op_q;
        acc_ovf_q <= 1'b0;
      end else begin
        acc_q     <= sum;
        acc_ovf_q <= acc_ovf_q | sum_ovf;
      end
    end
    if (signal_oe) begin
      data_out           <= acc_q;
      attr_out           <= '0;
      attr_out[OVERFLOW] <= acc_ovf_q;
    end
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every control/status output for the current cycle, then advance
  // to 1 time unit after the next rising edge.
  task automatic cyc(input string tag, input logic ld, input logic it, input logic ng,
                     input logic oe, input logic rv, input logic cr, input logic bz,
                     input logic er);
    #1;
    check({tag, ".load"},      signal_load, ld);
    check({tag, ".arg_ready"}, arg_ready,   ld);
    check({tag, ".init"},      signal_init, it);
    check({tag, ".neg"},       signal_neg,  ng);
    check({tag, ".oe"},        signal_oe,   oe);
    check({tag, ".res_valid"}, res_valid,   rv);
    check({tag, ".cmd_ready"}, cmd_ready,   cr);
    check({tag, ".busy"},      busy,        bz);
    check({tag, ".cmd_err"},   cmd_err,     er);
    $display("cycle %s: load=%b init=%b neg=%b oe=%b rv=%b rdy=%b busy=%b err=%b dout=%0h",
             tag, signal_load, signal_init, signal_neg, signal_oe, res_valid,
             cmd_ready, busy, cmd_err, data_out);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst          = 1'b0;
    cmd_valid    = 1'b0;
    cmd_count    = '0;
    cmd_neg_mask = '0;
    arg_valid    = 1'b0;
    res_ready    = 1'b0;
    data_in      = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst.res_ovf", res_ovf, 1'b0);
    cyc("rst", 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    cyc("rst_rel", 0, 0, 0, 0, 0, 1, 0, 0);

    // Job 1: count=3, mask=010, addends 5,7,2 with no stalls -> 5-7+2 = 0
    cmd_valid = 1'b1; cmd_count = 4'd3; cmd_neg_mask = 8'b0000_0010;
    arg_valid = 1'b1; data_in = 4'd5;
    cyc("t1.cmd", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    cyc("t1.ld0", 1, 1, 0, 0, 0, 0, 1, 0);
    data_in = 4'd7;
    cyc("t1.ld1", 1, 0, 1, 0, 0, 0, 1, 0);
    data_in = 4'd2;
    cyc("t1.ld2", 1, 0, 0, 0, 0, 0, 1, 0);
    arg_valid = 1'b0;
    cyc("t1.s1", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t1.s2", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t1.out", 0, 0, 0, 1, 0, 0, 1, 0);
    check("t1.data_out", data_out, 4'h0);
    res_ready = 1'b1;
    cyc("t1.hold", 0, 0, 0, 1, 1, 0, 1, 0);
    res_ready = 1'b0;
    cyc("t1.idle", 0, 0, 0, 0, 0, 1, 0, 0);

    // Job 2: count=2, mask=11, arg_valid 1,0,0,1 -> -3-4 = -7 (4'h9)
    cmd_valid = 1'b1; cmd_count = 4'd2; cmd_neg_mask = 8'b0000_0011;
    cyc("t2.cmd", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    arg_valid = 1'b1; data_in = 4'd3;
    cyc("t2.a0", 1, 1, 1, 0, 0, 0, 1, 0);
    arg_valid = 1'b0; data_in = 4'd9;
    cyc("t2.stall0", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t2.stall1", 0, 0, 0, 0, 0, 0, 1, 0);
    arg_valid = 1'b1; data_in = 4'd4;
    cyc("t2.a1", 1, 0, 1, 0, 0, 0, 1, 0);
    arg_valid = 1'b0;
    cyc("t2.s1", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t2.s2", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t2.out", 0, 0, 0, 1, 0, 0, 1, 0);
    check("t2.data_out", data_out, 4'h9);
    res_ready = 1'b1;
    cyc("t2.hold", 0, 0, 0, 1, 1, 0, 1, 0);
    res_ready = 1'b0;
    cyc("t2.idle", 0, 0, 0, 0, 0, 1, 0, 0);

    // Rejected jobs: count=0 and count=9, with arg_valid high throughout
    arg_valid = 1'b1;
    cmd_valid = 1'b1; cmd_count = 4'd0;
    cyc("t3.cmd0", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    cyc("t3.err0", 0, 0, 0, 0, 0, 1, 0, 1);
    cyc("t3.post0", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b1; cmd_count = 4'd9;
    cyc("t3.cmd9", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    cyc("t3.err9", 0, 0, 0, 0, 0, 1, 0, 1);
    cyc("t3.post9", 0, 0, 0, 0, 0, 1, 0, 0);
    arg_valid = 1'b0;

    // Job 4: count=8 (maximum), mask=8'h81, addends 1..8 -> -1+2+..+7-8 = 18 = 4'h2;
    // result then held for 6 cycles with res_ready low.
    cmd_valid = 1'b1; cmd_count = 4'd8; cmd_neg_mask = 8'h81;
    cyc("t4.cmd", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    arg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = DW'(i + 1);
      cyc($sformatf("t4.ld%0d", i), 1, (i == 0), (i == 0) || (i == 7), 0, 0, 0, 1, 0);
    end
    arg_valid = 1'b0;
    cyc("t4.s1", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t4.s2", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t4.out", 0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4.data_out%0d", i), data_out, 4'h2);
      cyc($sformatf("t4.hold%0d", i), 0, 0, 0, 1, 1, 0, 1, 0);
    end
    res_ready = 1'b1;
    cyc("t4.take", 0, 0, 0, 1, 1, 0, 1, 0);
    res_ready = 1'b0;
    cyc("t4.idle", 0, 0, 0, 0, 0, 1, 0, 0);

    // Job 5: reset during LOAD after 1 of 4 loads, then a count=1 job
    cmd_valid = 1'b1; cmd_count = 4'd4; cmd_neg_mask = 8'h00;
    cyc("t5.cmd", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    arg_valid = 1'b1; data_in = 4'd1;
    cyc("t5.ld0", 1, 1, 0, 0, 0, 0, 1, 0);
    check("t5.pre_rst.load", signal_load, 1'b1);
    rst = 1'b0;
    #1;
    check("t5.rst.load",      signal_load, 1'b0);
    check("t5.rst.busy",      busy,        1'b0);
    check("t5.rst.cmd_ready", cmd_ready,   1'b1);
    check("t5.rst.cmd_err",   cmd_err,     1'b0);
    check("t5.rst.res_valid", res_valid,   1'b0);
    cyc("t5.in_rst", 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    arg_valid = 1'b0;
    cyc("t5.idle", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b1; cmd_count = 4'd1; cmd_neg_mask = 8'h01;
    cyc("t5.cmd1", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    arg_valid = 1'b1; data_in = 4'd3;
    cyc("t5.ld", 1, 1, 1, 0, 0, 0, 1, 0);
    arg_valid = 1'b0;
    cyc("t5.s1", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t5.s2", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t5.out", 0, 0, 0, 1, 0, 0, 1, 0);
    check("t5.data_out", data_out, 4'hD);
    res_ready = 1'b1;
    cyc("t5.hold", 0, 0, 0, 1, 1, 0, 1, 0);
    res_ready = 1'b0;
    cyc("t5.done", 0, 0, 0, 0, 0, 1, 0, 0);

    // Job 6: addends 7,1 overflow a 4-bit signed accumulator
    cmd_valid = 1'b1; cmd_count = 4'd2; cmd_neg_mask = 8'h00;
    cyc("t6.cmd", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    check("t6.ovf_after_cmd", res_ovf, 1'b0);
    arg_valid = 1'b1; data_in = 4'd7;
    cyc("t6.ld0", 1, 1, 0, 0, 0, 0, 1, 0);
    data_in = 4'd1;
    cyc("t6.ld1", 1, 0, 0, 0, 0, 0, 1, 0);
    arg_valid = 1'b0;
    cyc("t6.s1", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t6.s2", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t6.out", 0, 0, 0, 1, 0, 0, 1, 0);
    check("t6.data_out", data_out, 4'h8);
    cyc("t6.hold0", 0, 0, 0, 1, 1, 0, 1, 0);
    check("t6.ovf_hold", res_ovf, EXP_OVF);
    res_ready = 1'b1;
    cyc("t6.hold1", 0, 0, 0, 1, 1, 0, 1, 0);
    res_ready = 1'b0;
    check("t6.ovf_idle0", res_ovf, EXP_OVF);
    cyc("t6.idle0", 0, 0, 0, 0, 0, 1, 0, 0);
    check("t6.ovf_idle1", res_ovf, EXP_OVF);
    cmd_valid = 1'b1; cmd_count = 4'd1; cmd_neg_mask = 8'h00;
    cyc("t6.cmd1", 0, 0, 0, 0, 0, 1, 0, 0);
    cmd_valid = 1'b0;
    check("t6.ovf_cleared", res_ovf, 1'b0);
    arg_valid = 1'b1; data_in = 4'd1;
    cyc("t6.ld", 1, 1, 0, 0, 0, 0, 1, 0);
    arg_valid = 1'b0;
    cyc("t6.s1b", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t6.s2b", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("t6.outb", 0, 0, 0, 1, 0, 0, 1, 0);
    check("t6.data_out_b", data_out, 4'h1);
    res_ready = 1'b1;
    cyc("t6.holdb", 0, 0, 0, 1, 1, 0, 1, 0);
    res_ready = 1'b0;
    check("t6.ovf_end", res_ovf, 1'b0);
    cyc("t6.idleb", 0, 0, 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
